code_entry_lock: RTL

CODE_ENTRY_LOCK -- requirements
Module: code_entry_lock

---
 rtl/lock_pkg.sv | 21 ++
 rtl/key_event.sv | 38 +++
 rtl/code_entry_lock.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the keypad code lock.
// Holds the special key values, the FSM state encoding and a digit-classification helper.
package lock_pkg;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam logic [3:0] KEY_PROG  = 4'hC;

  typedef enum logic [2:0] {
    StEntry,
    StCheck,
    StOpen,
    StProg,
    StLockout
  } lock_state_e;

  function automatic logic is_digit(input logic [3:0] key);
    return key < 4'd10;
  endfunction

endpackage

// File: rtl/key_event.sv
// Key event generator.
// Turns the keypad decoder's key-pressed level into a single-cycle event and
// captures the key value in the same cycle.
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   key_ping_i  key-pressed level (synchronous to clk_i)
//   key_code_i  decoded key value
//   key_evt_o   one-cycle pulse per press (a held key gives one pulse)
//   key_val_o   key value registered alongside the pulse
module key_event (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       key_ping_i,
  input  logic [3:0] key_code_i,
  output logic       key_evt_o,
  output logic [3:0] key_val_o
);

  logic       ping_q;
  logic       evt_q;
  logic [3:0] code_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ping_q <= 1'b0;
      evt_q  <= 1'b0;
      code_q <= 4'h0;
    end else begin
      ping_q <= key_ping_i;
      evt_q  <= key_ping_i & ~ping_q;
      code_q <= key_code_i;
    end
  end

  assign key_evt_o = evt_q;
  assign key_val_o = code_q;

endmodule

// File: rtl/code_entry_lock.sv
// Keypad code-entry lock.
// Buffers keypad digits, compares them against a programmable user code or a
// fixed master code, opens for a timed window, and locks out after repeated
// failures. The user code can be reprogrammed while the lock is open.
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   key_ping_i    key-pressed level
//   key_code_i    decoded key (0-9 digit, A enter, B clear, C program)
//   unlocked_o    high while open
//   alarm_o       high while in lockout
//   prog_mode_o   high while programming a new code
//   err_o         one-cycle pulse on a rejected enter
//   last_digit_o  most recently accepted digit
//   entry_cnt_o   number of digits currently buffered
module code_entry_lock
  import lock_pkg::*;
#(
  parameter int unsigned           DIGITS       = 4,
  parameter logic [4*DIGITS-1:0]   DEFAULT_CODE = 16'h1234,
  parameter logic [4*DIGITS-1:0]   MASTER_CODE  = 16'h9999,
  parameter int unsigned           MAX_FAIL     = 3,
  parameter int unsigned           OPEN_CYC     = 100000000,
  parameter int unsigned           LOCK_CYC     = 500000000
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        key_ping_i,
  input  logic [3:0]                  key_code_i,
  output logic                        unlocked_o,
  output logic                        alarm_o,
  output logic                        prog_mode_o,
  output logic                        err_o,
  output logic [3:0]                  last_digit_o,
  output logic [$clog2(DIGITS+1)-1:0] entry_cnt_o
);

  localparam int unsigned CntW   = $clog2(DIGITS + 1);
  localparam int unsigned FailW  = $clog2(MAX_FAIL + 1);
  localparam int unsigned TmrMax = (OPEN_CYC > LOCK_CYC) ? OPEN_CYC : LOCK_CYC;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);

  localparam logic [CntW-1:0]  CntFull  = CntW'(DIGITS);
  localparam logic [FailW-1:0] FailMax  = FailW'(MAX_FAIL);
  localparam logic [TmrW-1:0]  OpenLast = TmrW'(OPEN_CYC - 1);
  localparam logic [TmrW-1:0]  LockLast = TmrW'(LOCK_CYC - 1);

  logic       key_evt;
  logic [3:0] key_val;

  key_event u_key_event (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .key_ping_i (key_ping_i),
    .key_code_i (key_code_i),
    .key_evt_o  (key_evt),
    .key_val_o  (key_val)
  );

  lock_state_e          state_q, state_d;
  logic [4*DIGITS-1:0]  buf_q, buf_d;
  logic [4*DIGITS-1:0]  code_q, code_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [3:0]           last_q, last_d;
  logic [FailW-1:0]     fail_q, fail_d;
  logic [TmrW-1:0]      timer_q, timer_d;
  logic                 err_q, err_d;
  logic                 unlocked_q, alarm_q, prog_q;

  logic             match;
  logic [FailW-1:0] fail_inc;

  assign match    = (cnt_q == CntFull) && ((buf_q == code_q) || (buf_q == MASTER_CODE));
  assign fail_inc = (fail_q == FailMax) ? fail_q : fail_q + FailW'(1);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    err_d   = 1'b0;

    // Digit and clear handling is common to normal entry and programming.
    if (key_evt && (state_q == StEntry || state_q == StProg)) begin
      if (is_digit(key_val)) begin
        if (cnt_q != CntFull) begin
          buf_d      = buf_q << 4;
          buf_d[3:0] = key_val;
          cnt_d      = cnt_q + CntW'(1);
          last_d     = key_val;
        end
      end else if (key_val == KEY_CLEAR) begin
        buf_d  = '0;
        cnt_d  = '0;
        last_d = 4'h0;
      end
    end

    unique case (state_q)
      StEntry: begin
        if (key_evt && key_val == KEY_ENTER) state_d = StCheck;
      end
      StProg: begin
        if (key_evt && key_val == KEY_ENTER) begin
          if (cnt_q == CntFull) code_d = buf_q;
          else                  err_d  = 1'b1;
          buf_d   = '0;
          cnt_d   = '0;
          state_d = StEntry;
        end
      end
      StCheck: begin
        buf_d   = '0;
        cnt_d   = '0;
        timer_d = '0;
        if (match) begin
          fail_d  = '0;
          state_d = StOpen;
        end else begin
          err_d   = 1'b1;
          fail_d  = fail_inc;
          state_d = (fail_inc == FailMax) ? StLockout : StEntry;
        end
      end
      StOpen: begin
        if (key_evt && key_val == KEY_CLEAR) begin
          timer_d = '0;
          state_d = StEntry;
        end else if (key_evt && key_val == KEY_PROG) begin
          timer_d = '0;
          state_d = StProg;
        end else if (timer_q == OpenLast) begin
          timer_d = '0;
          state_d = StEntry;
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      StLockout: begin
        if (timer_q == LockLast) begin
          timer_d = '0;
          fail_d  = '0;
          state_d = StEntry;
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      default: state_d = StEntry;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StEntry;
      buf_q      <= '0;
      code_q     <= DEFAULT_CODE;
      cnt_q      <= '0;
      last_q     <= 4'h0;
      fail_q     <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
      prog_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      code_q     <= code_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      fail_q     <= fail_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      // Decoded from the next state so the flag is valid in the state's first cycle.
      unlocked_q <= (state_d == StOpen);
      alarm_q    <= (state_d == StLockout);
      prog_q     <= (state_d == StProg);
    end
  end

  assign unlocked_o   = unlocked_q;
  assign alarm_o      = alarm_q;
  assign prog_mode_o  = prog_q;
  assign err_o        = err_q;
  assign last_digit_o = last_q;
  assign entry_cnt_o  = cnt_q;

endmodule
